addr_mode_sequencer: RTL and testbench
======================================

Name: addr_mode_sequencer

Overview:
- Cycle-timing controller for the CPU control logic.
- Latches the opcode during fetch and decodes it to an addressing mode.
- Steps the shared state register through FETCH, the addressing cycles A0..A3 and the execute cycles E0..E3.
- Drives the state and mode-select lines consumed by the addressing-mode flag generators and the instruction flag generators. It also sequences the optional page-crossing cycle and the Indirect-Y carry hand-off.

Parameters:
- MAX_EXEC, 4, maximum execute cycles (E0..E3) before a forced return to FETCH.
- NOP_OPCODE, 8'hEA, value loaded into ir at reset.

Ports:
- clk  input  1  system clock; all registers rising-edge.
- nrst  input  1  asynchronous active-low reset.
- rdy  input  1  stall control; 0 freezes every register.
- opcode_in  input  8  data bus; sampled as opcode in FETCH.
- carry_in  input  1  ALU carry-out from the low-byte add.
- exec_done  input  1  from instruction logic: current E cycle is the last.
- state  output  4  current cycle state (package encoding).
- addr_mode  output  4  decoded addressing mode of ir (package enum).
- ir  output  8  latched opcode.
- sync  output  1  high while state==FETCH.
- carry_to_high_op  output  1  registered carry_in, valid during A2 of IND_Y.
- instr_done  output  1  one-cycle pulse on the last execute cycle.

Behaviour:
- Reset (nrst low, asynchronous) forces:
  - state=FETCH, ir=NOP_OPCODE, addr_mode=IMPLIED.
  - carry_to_high_op=0, instr_done=0, sync=1.
- Reset asserted mid-instruction abandons the instruction immediately.
- rdy=0 holds state, ir, carry_to_high_op and the internal flags. instr_done is forced 0 while stalled.
- FETCH with rdy=1: ir<=opcode_in. addr_mode is decoded from opcode_in combinationally, then from ir in all later states.
- Next state after FETCH: E0 for IMM/IMPLIED, otherwise A0.
- Addressing cycles per mode:
  - ZPG: A0.
  - ZPG_X, ZPG_Y, ABS: A0-A1.
  - ABS_X, ABS_Y: A0-A1, plus A2 conditionally.
  - IND_X, IND_Y: A0-A3.
- The last addressing cycle goes to E0.
- ABS_X/ABS_Y: carry_in is sampled at the end of A1.
  - A2 is entered if carry_in=1, or if ir[7:5]==3'b100 (store: always take the extra cycle).
  - Otherwise A1 goes to E0.
- IND_Y: carry_in is registered into carry_to_high_op at the end of A1. It holds through A2 and A3 and is cleared on entry to FETCH.
- Execute cycles:
  - From En: exec_done=1 gives FETCH with instr_done=1 in that En cycle.
  - Otherwise go to En+1.
  - E(MAX_EXEC-1) always goes to FETCH with instr_done=1, regardless of exec_done.
- Decode uses cc=op[1:0], bbb=op[4:2].
- cc=01: bbb 000 IND_X, 001 ZPG, 010 IMM, 011 ABS, 100 IND_Y, 101 ZPG_X, 110 ABS_Y, 111 ABS_X.
- cc=00/10:
  - bbb 000: IMM if op[7]=1, else IMPLIED.
  - 001 ZPG; 011 ABS.
  - 010/100/110: IMPLIED.
  - 101: ZPG_Y if cc=10 and op[7:6]=2'b10, else ZPG_X.
  - 111: ABS_Y if cc=10 and op[7:6]=2'b10, else ABS_X.
- cc=11: IMPLIED.
- Illegal state codes go to FETCH on the next enabled edge.

Decomposition:
- Shared package seq_pkg holds:
  - State constants FETCH=0, A0..A3=1..4, E0..E3=5..8.
  - addr_mode_t enum: IMPLIED, IMM, ZPG, ZPG_X, ZPG_Y, ABS, ABS_X, ABS_Y, IND_X, IND_Y.
  - Per-mode addressing cycle count constants.
- One sub-module: addr_mode_decode (combinational opcode to addr_mode_t), reused by the instruction decoder.

Test Plan:
- Reset then opcode_in=8'hA9 (LDA IMM), exec_done=1 in E0 -> FETCH, E0, FETCH; ir=A9; instr_done pulse in E0.
- opcode 8'hBD (LDA ABS_X): carry_in=0 at A1 -> A0, A1, E0; carry_in=1 -> A0, A1, A2, E0.
- opcode 8'h9D (STA ABS_X), carry_in=0 -> A2 still entered.
- opcode 8'h91 (STA IND_Y), carry_in=1 at end of A1 -> carry_to_high_op=1 in A2 and A3, 0 after FETCH.
- rdy=0 for 3 cycles in A1 of 8'hA1 (LDA IND_X) -> state holds A1; resumes A2, A3, E0.
- nrst pulsed low during E1 -> state=FETCH, ir=EA, sync=1 asynchronously. exec_done never asserted -> forced FETCH after E3.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg: shared cycle-state encoding, addressing modes and per-mode addressing cycle counts
package seq_pkg;

    localparam logic [3:0] FETCH = 4'd0;
    localparam logic [3:0] A0    = 4'd1;
    localparam logic [3:0] A1    = 4'd2;
    localparam logic [3:0] A2    = 4'd3;
    localparam logic [3:0] A3    = 4'd4;
    localparam logic [3:0] E0    = 4'd5;
    localparam logic [3:0] E1    = 4'd6;
    localparam logic [3:0] E2    = 4'd7;
    localparam logic [3:0] E3    = 4'd8;

    typedef enum logic [3:0] {
        IMPLIED, IMM, ZPG, ZPG_X, ZPG_Y, ABS, ABS_X, ABS_Y, IND_X, IND_Y
    } addr_mode_t;

    // Base addressing cycles; ABS_X/ABS_Y may add one page-crossing cycle on top
    localparam logic [2:0] CYC_NONE    = 3'd0;
    localparam logic [2:0] CYC_ZPG     = 3'd1;
    localparam logic [2:0] CYC_ZPG_IDX = 3'd2;
    localparam logic [2:0] CYC_ABS     = 3'd2;
    localparam logic [2:0] CYC_ABS_IDX = 3'd2;
    localparam logic [2:0] CYC_IND     = 3'd4;

    function automatic logic [2:0] addr_cycles(input addr_mode_t m);
        return (m == ZPG) ? CYC_ZPG :
               (m == ZPG_X || m == ZPG_Y) ? CYC_ZPG_IDX :
               (m == ABS) ? CYC_ABS :
               (m == ABS_X || m == ABS_Y) ? CYC_ABS_IDX :
               (m == IND_X || m == IND_Y) ? CYC_IND : CYC_NONE;
    endfunction

endpackage

// File: rtl/addr_mode_decode.sv
// addr_mode_decode: combinational opcode to addressing-mode decode
module addr_mode_decode
    import seq_pkg::*;
(
    input  logic [7:0] opcode,
    output addr_mode_t mode
);

    logic [1:0] cc;
    logic [2:0] bbb;
    logic       idx_y;

    assign cc    = opcode[1:0];
    assign bbb   = opcode[4:2];
    assign idx_y = (cc == 2'b10) && (opcode[7:6] == 2'b10);

    always_comb begin
        mode = IMPLIED;
        if (cc == 2'b01) begin
            case (bbb)
                3'b000:  mode = IND_X;
                3'b001:  mode = ZPG;
                3'b010:  mode = IMM;
                3'b011:  mode = ABS;
                3'b100:  mode = IND_Y;
                3'b101:  mode = ZPG_X;
                3'b110:  mode = ABS_Y;
                default: mode = ABS_X;
            endcase
        end else if (cc != 2'b11) begin
            case (bbb)
                3'b000:  mode = opcode[7] ? IMM : IMPLIED;
                3'b001:  mode = ZPG;
                3'b011:  mode = ABS;
                3'b101:  mode = idx_y ? ZPG_Y : ZPG_X;
                3'b111:  mode = idx_y ? ABS_Y : ABS_X;
                default: mode = IMPLIED;
            endcase
        end
    end

endmodule

// File: rtl/addr_mode_sequencer.sv
// addr_mode_sequencer: steps FETCH / addressing / execute cycles and latches the opcode
module addr_mode_sequencer
    import seq_pkg::*;
#(
    parameter int         MAX_EXEC   = 4,
    parameter logic [7:0] NOP_OPCODE = 8'hEA
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       rdy,
    input  logic [7:0] opcode_in,
    input  logic       carry_in,
    input  logic       exec_done,
    output logic [3:0] state,
    output addr_mode_t addr_mode,
    output logic [7:0] ir,
    output logic       sync,
    output logic       carry_to_high_op,
    output logic       instr_done
);

    localparam logic [3:0] E_LAST = 4'(E0 + MAX_EXEC - 1);

    logic [7:0] decode_op;
    logic [3:0] next_state;
    logic [2:0] cyc_done;
    logic       in_addr, in_exec, last_exec, page_cycle;

    // Decode the bus directly in FETCH so the mode is valid in the same cycle the opcode arrives
    assign decode_op = (state == FETCH && nrst) ? opcode_in : ir;

    addr_mode_decode u_decode (
        .opcode(decode_op),
        .mode  (addr_mode)
    );

    always_comb begin
        in_addr    = (state >= A0) && (state <= A3);
        in_exec    = (state >= E0) && (state <= E_LAST);
        last_exec  = in_exec && (exec_done || state == E_LAST);
        cyc_done   = 3'(state - A0 + 4'd1);
        page_cycle = (addr_mode == ABS_X || addr_mode == ABS_Y) && (state == A1) &&
                     (carry_in || ir[7:5] == 3'b100);
        next_state = (state == FETCH) ? ((addr_mode == IMM || addr_mode == IMPLIED) ? E0 : A0) :
                     in_addr ? (page_cycle ? A2 :
                                (cyc_done >= addr_cycles(addr_mode)) ? E0 : state + 4'd1) :
                     in_exec ? (last_exec ? FETCH : state + 4'd1) : FETCH;
        instr_done = rdy && last_exec;
    end

    assign sync = (state == FETCH);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state            <= FETCH;
            ir               <= NOP_OPCODE;
            carry_to_high_op <= 1'b0;
        end else if (rdy) begin
            state            <= next_state;
            ir               <= (state == FETCH) ? opcode_in : ir;
            carry_to_high_op <= (next_state == FETCH) ? 1'b0 :
                                (state == A1 && addr_mode == IND_Y) ? carry_in : carry_to_high_op;
        end
    end

endmodule

// File: tb/tb_addr_mode_sequencer.sv
// tb_addr_mode_sequencer: scoreboard-driven cycle checks of the addressing-mode sequencer
module tb_addr_mode_sequencer;
    import seq_pkg::*;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       rdy = 1'b1;
    logic [7:0] opcode_in = 8'hEA;
    logic       carry_in = 1'b0;
    logic       exec_done = 1'b0;
    logic [3:0] state;
    addr_mode_t addr_mode;
    logic [7:0] ir;
    logic       sync, carry_to_high_op, instr_done;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] opc;
        logic       r, c, x;
    } stim_t;

    typedef struct {
        logic [3:0] st;
        addr_mode_t m;
        logic       d, h;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    stim_t s;
    exp_t  e;

    addr_mode_sequencer #(.MAX_EXEC(4), .NOP_OPCODE(8'hEA)) dut (
        .clk(clk), .nrst(nrst), .rdy(rdy), .opcode_in(opcode_in), .carry_in(carry_in),
        .exec_done(exec_done), .state(state), .addr_mode(addr_mode), .ir(ir), .sync(sync),
        .carry_to_high_op(carry_to_high_op), .instr_done(instr_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic add(input logic [7:0] opc, input logic r, input logic c, input logic x,
                       input logic [3:0] st, input addr_mode_t m, input logic d, input logic h);
        stim_q.push_back('{opc, r, c, x});
        exp_q.push_back('{st, m, d, h});
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (state !== FETCH) begin failures++; $display("FAIL reset_state: got %0d want %0d", state, FETCH); end
        checks++;
        if (ir !== 8'hEA) begin failures++; $display("FAIL reset_ir: got %h want EA", ir); end
        checks++;
        if (addr_mode !== IMPLIED) begin failures++; $display("FAIL reset_mode: got %0d want %0d", addr_mode, IMPLIED); end
        checks++;
        if ({sync, carry_to_high_op, instr_done} !== 3'b100) begin
            failures++; $display("FAIL reset_flags: sync/cth/done got %b want 100", {sync, carry_to_high_op, instr_done});
        end
        nrst = 1'b1;
    endtask

    task automatic test_imm;
        add(8'hA9, 1, 0, 0, FETCH, IMM, 0, 0);
        add(8'hA9, 1, 0, 1, E0,    IMM, 1, 0);
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            opcode_in = s.opc; rdy = s.r; carry_in = s.c; exec_done = s.x;
            @(negedge clk);
            checks++;
            if ({state, addr_mode, instr_done, carry_to_high_op, sync} !== {e.st, e.m, e.d, e.h, e.st == FETCH}) begin
                failures++;
                $display("FAIL imm: st=%0d mode=%0d done=%b cth=%b sync=%b want st=%0d mode=%0d done=%b cth=%b",
                         state, addr_mode, instr_done, carry_to_high_op, sync, e.st, e.m, e.d, e.h);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (state !== FETCH || ir !== 8'hA9) begin
            failures++; $display("FAIL imm_end: st=%0d ir=%h want st=0 ir=A9", state, ir);
        end
    endtask

    task automatic test_abs_x;
        add(8'hBD, 1, 0, 0, FETCH, ABS_X, 0, 0);
        add(8'hBD, 1, 0, 0, A0,    ABS_X, 0, 0);
        add(8'hBD, 1, 0, 0, A1,    ABS_X, 0, 0);
        add(8'hBD, 1, 0, 1, E0,    ABS_X, 1, 0);
        add(8'hBD, 1, 0, 0, FETCH, ABS_X, 0, 0);
        add(8'hBD, 1, 0, 0, A0,    ABS_X, 0, 0);
        add(8'hBD, 1, 1, 0, A1,    ABS_X, 0, 0);
        add(8'hBD, 1, 0, 0, A2,    ABS_X, 0, 0);
        add(8'hBD, 1, 0, 1, E0,    ABS_X, 1, 0);
        add(8'h9D, 1, 0, 0, FETCH, ABS_X, 0, 0);
        add(8'h9D, 1, 0, 0, A0,    ABS_X, 0, 0);
        add(8'h9D, 1, 0, 0, A1,    ABS_X, 0, 0);
        add(8'h9D, 1, 0, 0, A2,    ABS_X, 0, 0);
        add(8'h9D, 1, 0, 1, E0,    ABS_X, 1, 0);
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            opcode_in = s.opc; rdy = s.r; carry_in = s.c; exec_done = s.x;
            @(negedge clk);
            checks++;
            if ({state, addr_mode, instr_done, carry_to_high_op, sync} !== {e.st, e.m, e.d, e.h, e.st == FETCH}) begin
                failures++;
                $display("FAIL abs_x op=%h: st=%0d mode=%0d done=%b cth=%b sync=%b want st=%0d mode=%0d done=%b cth=%b",
                         s.opc, state, addr_mode, instr_done, carry_to_high_op, sync, e.st, e.m, e.d, e.h);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ind_y;
        add(8'h91, 1, 0, 0, FETCH, IND_Y, 0, 0);
        add(8'h91, 1, 0, 0, A0,    IND_Y, 0, 0);
        add(8'h91, 1, 1, 0, A1,    IND_Y, 0, 0);
        add(8'h91, 1, 0, 0, A2,    IND_Y, 0, 1);
        add(8'h91, 1, 0, 0, A3,    IND_Y, 0, 1);
        add(8'h91, 1, 0, 1, E0,    IND_Y, 1, 1);
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            opcode_in = s.opc; rdy = s.r; carry_in = s.c; exec_done = s.x;
            @(negedge clk);
            checks++;
            if ({state, addr_mode, instr_done, carry_to_high_op, sync} !== {e.st, e.m, e.d, e.h, e.st == FETCH}) begin
                failures++;
                $display("FAIL ind_y: st=%0d mode=%0d done=%b cth=%b sync=%b want st=%0d mode=%0d done=%b cth=%b",
                         state, addr_mode, instr_done, carry_to_high_op, sync, e.st, e.m, e.d, e.h);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (state !== FETCH || carry_to_high_op !== 1'b0) begin
            failures++; $display("FAIL ind_y_clear: st=%0d cth=%b want st=0 cth=0", state, carry_to_high_op);
        end
    endtask

    task automatic test_stall;
        add(8'hA1, 1, 0, 0, FETCH, IND_X, 0, 0);
        add(8'hA1, 1, 0, 0, A0,    IND_X, 0, 0);
        add(8'hA1, 0, 1, 0, A1,    IND_X, 0, 0);
        add(8'hA1, 0, 1, 0, A1,    IND_X, 0, 0);
        add(8'hA1, 0, 1, 0, A1,    IND_X, 0, 0);
        add(8'hA1, 1, 0, 0, A1,    IND_X, 0, 0);
        add(8'hA1, 1, 0, 0, A2,    IND_X, 0, 0);
        add(8'hA1, 1, 0, 0, A3,    IND_X, 0, 0);
        add(8'hA1, 0, 0, 1, E0,    IND_X, 0, 0);
        add(8'hA1, 1, 0, 1, E0,    IND_X, 1, 0);
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            opcode_in = s.opc; rdy = s.r; carry_in = s.c; exec_done = s.x;
            @(negedge clk);
            checks++;
            if ({state, addr_mode, instr_done, carry_to_high_op, sync} !== {e.st, e.m, e.d, e.h, e.st == FETCH}) begin
                failures++;
                $display("FAIL stall rdy=%b: st=%0d mode=%0d done=%b cth=%b sync=%b want st=%0d mode=%0d done=%b cth=%b",
                         s.r, state, addr_mode, instr_done, carry_to_high_op, sync, e.st, e.m, e.d, e.h);
            end
            @(posedge clk); #1;
        end
        rdy = 1'b1;
    endtask

    task automatic test_reset_mid_and_forced;
        add(8'hAD, 1, 0, 0, FETCH, ABS, 0, 0);
        add(8'hAD, 1, 0, 0, A0,    ABS, 0, 0);
        add(8'hAD, 1, 0, 0, A1,    ABS, 0, 0);
        add(8'hAD, 1, 0, 0, E0,    ABS, 0, 0);
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            opcode_in = s.opc; rdy = s.r; carry_in = s.c; exec_done = s.x;
            @(negedge clk);
            checks++;
            if ({state, addr_mode, instr_done, carry_to_high_op, sync} !== {e.st, e.m, e.d, e.h, e.st == FETCH}) begin
                failures++;
                $display("FAIL pre_reset: st=%0d mode=%0d done=%b cth=%b sync=%b want st=%0d mode=%0d done=%b cth=%b",
                         state, addr_mode, instr_done, carry_to_high_op, sync, e.st, e.m, e.d, e.h);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (state !== E1) begin failures++; $display("FAIL mid_state: got %0d want %0d", state, E1); end
        opcode_in = 8'hEA;
        nrst = 1'b0;
        #1;
        checks++;
        if ({state, ir, sync, instr_done} !== {FETCH, 8'hEA, 1'b1, 1'b0}) begin
            failures++; $display("FAIL async_reset: st=%0d ir=%h sync=%b done=%b want st=0 ir=EA sync=1 done=0",
                                 state, ir, sync, instr_done);
        end
        #1;
        nrst = 1'b1;
        add(8'hAD, 1, 0, 0, FETCH, ABS, 0, 0);
        add(8'hAD, 1, 0, 0, A0,    ABS, 0, 0);
        add(8'hAD, 1, 0, 0, A1,    ABS, 0, 0);
        add(8'hAD, 1, 0, 0, E0,    ABS, 0, 0);
        add(8'hAD, 1, 0, 0, E1,    ABS, 0, 0);
        add(8'hAD, 1, 0, 0, E2,    ABS, 0, 0);
        add(8'hAD, 1, 0, 0, E3,    ABS, 1, 0);
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            opcode_in = s.opc; rdy = s.r; carry_in = s.c; exec_done = s.x;
            @(negedge clk);
            checks++;
            if ({state, addr_mode, instr_done, carry_to_high_op, sync} !== {e.st, e.m, e.d, e.h, e.st == FETCH}) begin
                failures++;
                $display("FAIL forced_exec: st=%0d mode=%0d done=%b cth=%b sync=%b want st=%0d mode=%0d done=%b cth=%b",
                         state, addr_mode, instr_done, carry_to_high_op, sync, e.st, e.m, e.d, e.h);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (state !== FETCH) begin failures++; $display("FAIL forced_return: got %0d want %0d", state, FETCH); end
    endtask

    task automatic test_back_to_back;
        add(8'hB6, 1, 0, 0, FETCH, ZPG_Y,   0, 0);
        add(8'hB6, 1, 0, 0, A0,    ZPG_Y,   0, 0);
        add(8'hB6, 1, 0, 0, A1,    ZPG_Y,   0, 0);
        add(8'hB6, 1, 0, 1, E0,    ZPG_Y,   1, 0);
        add(8'h0A, 1, 0, 0, FETCH, IMPLIED, 0, 0);
        add(8'h0A, 1, 0, 0, E0,    IMPLIED, 0, 0);
        add(8'h0A, 1, 0, 1, E1,    IMPLIED, 1, 0);
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            opcode_in = s.opc; rdy = s.r; carry_in = s.c; exec_done = s.x;
            @(negedge clk);
            checks++;
            if ({state, addr_mode, instr_done, carry_to_high_op, sync} !== {e.st, e.m, e.d, e.h, e.st == FETCH}) begin
                failures++;
                $display("FAIL back_to_back op=%h: st=%0d mode=%0d done=%b cth=%b sync=%b want st=%0d mode=%0d done=%b cth=%b",
                         s.opc, state, addr_mode, instr_done, carry_to_high_op, sync, e.st, e.m, e.d, e.h);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (state !== FETCH || ir !== 8'h0A) begin
            failures++; $display("FAIL back_to_back_end: st=%0d ir=%h want st=0 ir=0A", state, ir);
        end
    endtask

    initial begin
        test_reset();
        test_imm();
        test_abs_x();
        test_ind_y();
        test_stall();
        test_reset_mid_and_forced();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
